srl_tap_delay: RTL and testbench

SRL_TAP_DELAY -- requirements
Module: srl_tap_delay

---
 rtl/srl_pkg.sv | 21 ++
 rtl/srl_tap_core.sv | 45 ++++
 rtl/srl_tap_delay.sv | 105 ++++++++++
 tb/tb_srl_tap_delay.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/srl_pkg.sv
// Shared constants and helpers for the SRL tap delay line.
package srl_pkg;

  localparam int unsigned SRL_DEPTH_MIN = 16;
  localparam int unsigned SRL_DEPTH_MAX = 1024;

  // Ceiling log2; exact for the power-of-two depths this block accepts.
  function automatic int unsigned srl_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit srl_depth_ok(input int unsigned v);
    return (v >= SRL_DEPTH_MIN) && (v <= SRL_DEPTH_MAX) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/srl_tap_core.sv
// Unreset WIDTH x DEPTH shift storage with combinational tap read(s).
// Second read port present when SRL_TAP_DELAY_DUAL_TAP_EN is defined.
module srl_tap_core
  import srl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        ce,
  input  logic [WIDTH-1:0]            d,
  input  logic [srl_log2(DEPTH)-1:0]  a,
  output logic [WIDTH-1:0]            tap_a
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  ,
  input  logic [srl_log2(DEPTH)-1:0]  b,
  output logic [WIDTH-1:0]            tap_b
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (ce) begin
      mem_d[0] = d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  // No reset on purpose: keeps the storage mappable to SRL primitives.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tap_a = mem_q[a];

`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  assign tap_b = mem_q[b];
`endif

endmodule

// File: rtl/srl_tap_delay.sv
// Variable-tap delay line: fill tracking, stale-data masking, registered taps.
// Define SRL_TAP_DELAY_DUAL_TAP_EN to add the independent second tap (b/z/zvld).
module srl_tap_delay
  import srl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [WIDTH-1:0]            d,
  input  logic [srl_log2(DEPTH)-1:0]  a,
  output logic [WIDTH-1:0]            y,
  output logic                        vld
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  ,
  input  logic [srl_log2(DEPTH)-1:0]  b,
  output logic [WIDTH-1:0]            z,
  output logic                        zvld
`endif
);

  localparam int unsigned AW = srl_log2(DEPTH);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  if (!srl_depth_ok(DEPTH)) begin : g_bad_depth
    $error("srl_tap_delay: DEPTH must be a power of two in 16..1024");
  end

  logic [WIDTH-1:0] tap_a;
  logic [AW:0]      fill_q, fill_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic             hit_a;

`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  logic [WIDTH-1:0] tap_b;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zvld_q, zvld_d;
  logic             hit_b;
`endif

  srl_tap_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .ce    (ce),
    .d     (d),
    .a     (a),
    .tap_a (tap_a)
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    ,
    .b     (b),
    .tap_b (tap_b)
`endif
  );

  // Shift is never gated by rst; only fill and outputs clear.
  always_comb begin
    fill_d = fill_q;
    if (ce && (fill_q != FILL_MAX)) fill_d = fill_q + (AW+1)'(1);

    hit_a = ({1'b0, a} < fill_q);
    y_d   = hit_a ? tap_a : '0;
    vld_d = hit_a;

    if (rst) begin
      fill_d = '0;
      y_d    = '0;
      vld_d  = 1'b0;
    end
  end

`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  always_comb begin
    hit_b  = ({1'b0, b} < fill_q);
    z_d    = hit_b ? tap_b : '0;
    zvld_d = hit_b;
    if (rst) begin
      z_d    = '0;
      zvld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
    y_q    <= y_d;
    vld_q  <= vld_d;
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    z_q    <= z_d;
    zvld_q <= zvld_d;
`endif
  end

  assign y   = y_q;
  assign vld = vld_q;
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  assign z    = z_q;
  assign zvld = zvld_q;
`endif

endmodule

// File: tb/tb_srl_tap_delay.sv
// Self-checking bench for srl_tap_delay (WIDTH=8, DEPTH=128).
module tb_srl_tap_delay;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ce  = 1'b0;
  logic [WIDTH-1:0] d   = '0;
  logic [AW-1:0]    a   = '0;
  logic [WIDTH-1:0] y;
  logic             vld;
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
  logic [AW-1:0]    b   = '0;
  logic [WIDTH-1:0] z;
  logic             zvld;
`endif

  always #5 clk = ~clk;

  srl_tap_delay #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .d    (d),
    .a    (a),
    .y    (y),
    .vld  (vld)
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    ,
    .b    (b),
    .z    (z),
    .zvld (zvld)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: every sample ever written (newest first) plus samples since reset.
  logic [WIDTH-1:0] hist[$];
  int               fill_m = 0;
  logic [WIDTH-1:0] exp_y, exp_z;
  logic             exp_vld, exp_zvld;

  function automatic logic [WIDTH-1:0] mdl_tap(input int addr);
    return (fill_m > addr) ? hist[addr] : '0;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock: drive inputs, predict outputs from pre-edge model state, advance model.
  task automatic tick(input logic r, input logic c, input logic [WIDTH-1:0] dd,
                      input logic [AW-1:0] aa, input logic [AW-1:0] bb);
    rst = r; ce = c; d = dd; a = aa;
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    b = bb;
`endif
    exp_y    = r ? '0 : mdl_tap(int'(aa));
    exp_vld  = r ? 1'b0 : (fill_m > int'(aa));
    exp_z    = r ? '0 : mdl_tap(int'(bb));
    exp_zvld = r ? 1'b0 : (fill_m > int'(bb));
    @(posedge clk);
    if (c) begin
      hist.push_front(dd);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    if (r) fill_m = 0;
    else if (c && fill_m < DEPTH) fill_m++;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_y"}, y, exp_y);
    check({tag, "_vld"}, {7'd0, vld}, {7'd0, exp_vld});
`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    check({tag, "_z"}, z, exp_z);
    check({tag, "_zvld"}, {7'd0, zvld}, {7'd0, exp_zvld});
`endif
  endtask

  typedef struct {
    logic             rst;
    logic             ce;
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] ey;
    logic             ev;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{rst:1'b1, ce:1'b0, d:8'h00, a:7'd0, ey:8'h00, ev:1'b0};
    vecs[1] = '{rst:1'b0, ce:1'b1, d:8'h5A, a:7'd0, ey:8'h00, ev:1'b0};
    vecs[2] = '{rst:1'b0, ce:1'b0, d:8'h00, a:7'd0, ey:8'h5A, ev:1'b1};
    vecs[3] = '{rst:1'b0, ce:1'b1, d:8'h3C, a:7'd1, ey:8'h00, ev:1'b0};
    vecs[4] = '{rst:1'b0, ce:1'b0, d:8'h00, a:7'd1, ey:8'h5A, ev:1'b1};
    vecs[5] = '{rst:1'b0, ce:1'b0, d:8'h00, a:7'd0, ey:8'h3C, ev:1'b1};
    vecs[6] = '{rst:1'b0, ce:1'b0, d:8'h00, a:7'd2, ey:8'h00, ev:1'b0};

    // Reset state
    tick(1'b1, 1'b0, 8'h00, 7'd0, 7'd0);
    tick(1'b1, 1'b0, 8'h00, 7'd0, 7'd0);
    check("reset_y", y, 8'h00);
    check("reset_vld", {7'd0, vld}, 8'h00);

    // Basic delay and small-address table
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].rst, vecs[i].ce, vecs[i].d, vecs[i].a, 7'd0);
      check($sformatf("vec%0d_y", i), y, vecs[i].ey);
      check($sformatf("vec%0d_vld", i), {7'd0, vld}, {7'd0, vecs[i].ev});
    end

    // Maximum depth
    tick(1'b1, 1'b0, 8'h00, 7'd127, 7'd0);
    for (int i = 0; i < 128; i++) begin
      tick(1'b0, 1'b1, 8'(i), 7'd127, 7'd0);
      check($sformatf("maxd_fill%0d_vld", i), {7'd0, vld}, 8'h00);
      check($sformatf("maxd_fill%0d_y", i), y, 8'h00);
    end
    tick(1'b0, 1'b0, 8'h00, 7'd127, 7'd0);
    check("maxd_full_y", y, 8'h00);
    check("maxd_full_vld", {7'd0, vld}, 8'h01);
    tick(1'b0, 1'b1, 8'hFF, 7'd127, 7'd0);
    tick(1'b0, 1'b0, 8'h00, 7'd127, 7'd0);
    check("maxd_next_y", y, 8'h01);

    // Hold with ce low
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 8'(8'hC0 + i), 7'd127, 7'd0);
      check($sformatf("hold%0d_y", i), y, 8'h01);
      check($sformatf("hold%0d_vld", i), {7'd0, vld}, 8'h01);
    end

    // Address step
    tick(1'b1, 1'b0, 8'h00, 7'd0, 7'd0);
    for (int i = 0; i < 128; i++) tick(1'b0, 1'b1, 8'(i), 7'd0, 7'd0);
    tick(1'b0, 1'b0, 8'h00, 7'd3, 7'd0);
    check("astep3_y", y, 8'd124);
    tick(1'b0, 1'b0, 8'h00, 7'd10, 7'd0);
    check("astep10_y", y, 8'd117);
    tick(1'b0, 1'b0, 8'h00, 7'd0, 7'd0);
    check("astep0_y", y, 8'd127);

    // Reset mid-stream with ce on the same edge; stale data must stay masked
    tick(1'b1, 1'b1, 8'hAA, 7'd4, 7'd0);
    check("midrst_y", y, 8'h00);
    check("midrst_vld", {7'd0, vld}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 8'(8'h10 + i), 7'd4, 7'd0);
      check($sformatf("refill%0d_vld", i), {7'd0, vld}, 8'h00);
      check($sformatf("refill%0d_y", i), y, 8'h00);
    end
    tick(1'b0, 1'b0, 8'h00, 7'd4, 7'd0);
    check("refill_done_vld", {7'd0, vld}, 8'h01);
    check("refill_done_y", y, 8'h10);

`ifdef SRL_TAP_DELAY_DUAL_TAP_EN
    // Dual tap: newest on a, oldest on b, random stream
    tick(1'b1, 1'b0, 8'h00, 7'd0, 7'd127);
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 1'b1, 8'($urandom), 7'd0, 7'd127);
      check_model($sformatf("dual%0d", i));
    end
`endif

    // Randomized run against the model
    tick(1'b1, 1'b0, 8'h00, 7'd0, 7'd0);
    for (int i = 0; i < 3000; i++) begin
      logic r, c;
      logic [AW-1:0] ra, rb;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 9) < 7);
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 7)) : 7'($urandom);
      rb = 7'($urandom);
      tick(r, c, 8'($urandom), ra, rb);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
